cfg_bank_arbiter: RTL and testbench
===================================

// Module: cfg_bank_arbiter
// PURPOSE
//  Round-robin arbiter sharing a single config/status register-bank access port
//  among NUM_REQ requesters (SPI register slave, on-chip sequencer, debug port).
//  Serialises one read or write at a time and returns the read data plus a write-protect error.
//  Supports an optional per-requester lock that holds the grant for back-to-back bursts.
//  Sits between the requesters and the register bank.
// PARAMETERS
//  NUM_REQ      2   number of requesters, >=2
//  ADDR_W       4   register address width
//  REG_W        8   register data width
//  NUM_CFG      8   addresses [0..NUM_CFG-1] writable; addresses >=NUM_CFG read-only (status)
//  LOCK_TIMEOUT 15  idle cycles before a held lock auto-releases; 0 = lock feature disabled
// PORTS
//  clk        in   1              system clock, all logic on posedge
//  rst        in   1              asynchronous, active-high reset
//  ena        in   1              block enable; low = no new accepts, in-flight access completes
//  req_valid  in   NUM_REQ        request valid, one bit per requester
//  req_we     in   NUM_REQ        1 = write, 0 = read
//  req_lock   in   NUM_REQ        keep grant after this transaction
//  req_addr   in   NUM_REQ*ADDR_W packed, requester i at [i*ADDR_W +: ADDR_W]
//  req_wdata  in   NUM_REQ*REG_W  packed, requester i at [i*REG_W +: REG_W]
//  req_ready  out  NUM_REQ        accept strobe, one-hot or zero (combinational)
//  rsp_valid  out  NUM_REQ        response strobe, one-hot or zero, 1 cycle
//  rsp_rdata  out  REG_W          read data, valid with rsp_valid (0 for writes)
//  rsp_err    out  1              write to read-only address, valid with rsp_valid
//  bank_we    out  1              bank write strobe, 1 cycle
//  bank_addr  out  ADDR_W         bank address
//  bank_wdata out  REG_W          bank write data
//  bank_rdata in   REG_W          bank combinational read data for bank_addr
//  grant_id   out  $clog2(NUM_REQ) index of last accepted requester
// BEHAVIOUR
//  Reset: state IDLE; req_ready, rsp_valid, rsp_rdata, rsp_err, bank_we, bank_addr, bank_wdata
//   all 0; grant_id 0; lock inactive; RR pointer = NUM_REQ-1, so requester 0 has first priority.
//  FSM IDLE -> ACCESS -> RESP -> IDLE. One transaction every 3 cycles max.
//  IDLE:
//   - Winner = first requester with req_valid, searching from ptr+1 cyclically.
//   - When a lock is active, only the lock owner is eligible.
//   - req_ready[winner] = ena. On valid&ready: latch we/addr/wdata/lock/id,
//     ptr <= id, grant_id <= id, goto ACCESS.
//  ACCESS (1 cycle):
//   - bank_addr/bank_wdata driven from latch.
//   - bank_we = we && (addr < NUM_CFG).
//   - rsp_rdata <= we ? 0 : bank_rdata; rsp_err <= we && (addr >= NUM_CFG).
//   - Blocked write: no bank_we, err flagged.
//  RESP (1 cycle): rsp_valid[id] = 1; goto IDLE. Latency: accept edge -> rsp_valid = 2 cycles.
//  bank_addr holds the last value outside ACCESS; bank_we is 0 outside ACCESS.
//  Lock (LOCK_TIMEOUT>0):
//   - Accepted req with lock=1 sets owner = id and loads timer = LOCK_TIMEOUT.
//   - Accepted owner req with lock=0 clears the lock at the end of the transaction.
//   - Timer decrements each IDLE cycle while ena=1 and the owner's req_valid=0.
//     When the timer reaches 0, the lock clears and normal round-robin resumes.
//   - Timer reloads on each owner accept.
//   - LOCK_TIMEOUT=0: req_lock ignored.
//  ena=0: no accepts and timer frozen; an ACCESS/RESP already in progress completes normally.
//  req_valid may drop without acceptance (no stickiness required). Simultaneous requests are
//   resolved only by the pointer. Asserting rst mid-transaction aborts it: no rsp_valid.
// TESTING
//  1. Reset, then req0 write addr 3 data 0xA5 -> ready0 at cycle 0, bank_we=1 addr=3 at cycle 1,
//     rsp_valid=01 rsp_err=0 at cycle 2.
//  2. req0 and req1 valid every cycle -> grants alternate 0,1,0,1; each granted every 6 cycles.
//  3. Write addr 9 (NUM_CFG=8) -> bank_we stays 0, rsp_err=1; read addr 9 with bank_rdata=0x3C
//     -> rsp_rdata=0x3C, err=0.
//  4. req1 lock=1 then req1 silent, req0 valid -> req0 blocked 15 IDLE cycles then granted;
//     req1 lock=0 write releases immediately.
//  5. ena=0 at ACCESS -> rsp_valid still asserted next cycle; no new ready while ena=0.
//  6. rst pulse in ACCESS -> all outputs 0 asynchronously, no rsp_valid, requester 0 priority.

Source files
------------

// File: rtl/cfg_bank_arbiter.sv
// Round-robin arbiter that shares one config/status register-bank port among NUM_REQ
// requesters. One read or write is in flight at a time (IDLE -> ACCESS -> RESP).
// A requester may hold a lock on the grant for bursts; an idle lock times out.
module cfg_bank_arbiter #(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned ADDR_W       = 4,
    parameter int unsigned REG_W        = 8,
    parameter int unsigned NUM_CFG      = 8,
    parameter int unsigned LOCK_TIMEOUT = 15,
    localparam int unsigned ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ena,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*REG_W-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [REG_W-1:0]          rsp_rdata,
    output logic                      rsp_err,
    output logic                      bank_we,
    output logic [ADDR_W-1:0]         bank_addr,
    output logic [REG_W-1:0]          bank_wdata,
    input  logic [REG_W-1:0]          bank_rdata,
    output logic [ID_W-1:0]           grant_id
);

    localparam int unsigned TMR_W = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
    localparam bit          LOCK_EN = (LOCK_TIMEOUT > 0);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    // Pointer starts at the last requester so requester 0 wins first after reset.
    localparam logic [ID_W-1:0]  PTR_RST  = ID_W'(NUM_REQ - 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(LOCK_TIMEOUT);

    logic [1:0]         state;
    logic [ID_W-1:0]    ptr;
    logic               lat_we;
    logic               lat_lock;
    logic               lock_active;
    logic [ID_W-1:0]    lock_owner;
    logic [TMR_W-1:0]   lock_timer;

    logic [NUM_REQ-1:0] eligible;
    logic               win_found;
    logic [ID_W-1:0]    win_id;
    logic               accept;
    logic               addr_cfg;

    // Restrict candidates to the lock owner while a lock is held.
    always_comb begin
        eligible = req_valid;
        if (lock_active) begin
            eligible = req_valid & (NUM_REQ'(1) << lock_owner);
        end
    end

    // Cyclic search for the first eligible requester after the pointer.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        win_found = 1'b0;
        win_id    = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = (32'(ptr) + k) % NUM_REQ;
            if (!win_found && eligible[ID_W'(idx)]) begin
                win_found = 1'b1;
                win_id    = ID_W'(idx);
            end
        end
    end

    // Handshake, response strobe and bank write strobe.
    always_comb begin
        accept    = (state == ST_IDLE) && ena && win_found;
        req_ready = accept ? (NUM_REQ'(1) << win_id) : '0;
        rsp_valid = (state == ST_RESP) ? (NUM_REQ'(1) << grant_id) : '0;
        addr_cfg  = (32'(bank_addr) < NUM_CFG);
        bank_we   = (state == ST_ACCESS) && lat_we && addr_cfg;
    end

    // Transaction FSM; bank_addr/bank_wdata double as the request latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            ptr        <= PTR_RST;
            grant_id   <= '0;
            lat_we     <= 1'b0;
            lat_lock   <= 1'b0;
            bank_addr  <= '0;
            bank_wdata <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        lat_we     <= req_we[win_id];
                        lat_lock   <= LOCK_EN && req_lock[win_id];
                        bank_addr  <= req_addr[win_id*ADDR_W +: ADDR_W];
                        bank_wdata <= req_wdata[win_id*REG_W +: REG_W];
                        ptr        <= win_id;
                        grant_id   <= win_id;
                        state      <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    rsp_rdata <= lat_we ? '0 : bank_rdata;
                    rsp_err   <= lat_we && !addr_cfg;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Lock ownership and idle timeout; only the owner can be accepted while locked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_active <= 1'b0;
            lock_owner  <= '0;
            lock_timer  <= '0;
        end else if (LOCK_EN) begin
            if (accept) begin
                if (req_lock[win_id]) begin
                    lock_active <= 1'b1;
                    lock_owner  <= win_id;
                    lock_timer  <= TMR_LOAD;
                end else if (lock_active) begin
                    // Owner's unlocking transaction; the lock drops when it completes.
                    lock_timer <= TMR_LOAD;
                end
            end else if (state == ST_RESP && !lat_lock) begin
                lock_active <= 1'b0;
            end else if (state == ST_IDLE && lock_active && ena && !req_valid[lock_owner]) begin
                if (lock_timer <= TMR_W'(1)) begin
                    lock_active <= 1'b0;
                    lock_timer  <= '0;
                end else begin
                    lock_timer <= lock_timer - TMR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_cfg_bank_arbiter.sv
// Self-checking bench for cfg_bank_arbiter: directed scenarios plus a randomized run
// compared against a transaction-level reference model of the arbiter and register bank.
`timescale 1ns/1ps
module tb_cfg_bank_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [1:0] req_valid, req_we, req_lock;
    logic [7:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0] req_ready, rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err, bank_we;
    logic [3:0] bank_addr;
    logic [7:0] bank_wdata, bank_rdata;
    logic       grant_id;

    logic [7:0] cfg_mem [8];
    logic [7:0] status_seed = 8'h00;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cfg_bank_arbiter #(
        .NUM_REQ(2), .ADDR_W(4), .REG_W(8), .NUM_CFG(8), .LOCK_TIMEOUT(15)
    ) dut (
        .clk(clk), .rst(rst), .ena(ena),
        .req_valid(req_valid), .req_we(req_we), .req_lock(req_lock),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .bank_we(bank_we), .bank_addr(bank_addr), .bank_wdata(bank_wdata),
        .bank_rdata(bank_rdata), .grant_id(grant_id)
    );

    // Register bank: 8 writable cells, read-only status derived from the address.
    function automatic logic [7:0] status_of(input logic [3:0] a);
        return status_seed ^ {4'h0, a};
    endfunction

    assign bank_rdata = (bank_addr < 4'd8) ? cfg_mem[bank_addr[2:0]] : status_of(bank_addr);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) cfg_mem[i] <= 8'h00;
        end else if (bank_we) begin
            cfg_mem[bank_addr[2:0]] <= bank_wdata;
        end
    end

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic clear_reqs();
        req_valid = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
    endtask

    task automatic set_req(input int i, input bit we, input bit lk, input logic [3:0] a,
                           input logic [7:0] d);
        req_valid[i] = 1'b1; req_we[i] = we; req_lock[i] = lk;
        req_addr[i*4 +: 4] = a; req_wdata[i*8 +: 8] = d;
    endtask

    task automatic test_reset();
        rst = 1'b1; ena = 1'b1; clear_reqs();
        @(posedge clk); #1;
        n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL rst_ready: got %b want 00", req_ready); end
        n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rst_rsp_valid: got %b want 00", rsp_valid); end
        n_checks++; if (rsp_rdata !== 8'h00 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL rst_rsp: got %h/%b want 00/0", rsp_rdata, rsp_err); end
        n_checks++; if (bank_we !== 1'b0 || bank_addr !== 4'h0 || bank_wdata !== 8'h00) begin n_fail++; $display("FAIL rst_bank: got %b/%h/%h want 0/0/00", bank_we, bank_addr, bank_wdata); end
        n_checks++; if (grant_id !== 1'b0) begin n_fail++; $display("FAIL rst_grant: got %b want 0", grant_id); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_write_basic();
        next_cycle(); clear_reqs(); set_req(0, 1, 0, 4'd3, 8'hA5); #1;
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL wr_ready: got %b want 01", req_ready); end
        next_cycle(); clear_reqs(); #1;
        n_checks++; if (bank_we !== 1'b1 || bank_addr !== 4'd3 || bank_wdata !== 8'hA5) begin n_fail++; $display("FAIL wr_bank: got %b/%h/%h want 1/3/a5", bank_we, bank_addr, bank_wdata); end
        n_checks++; if (rsp_valid !== 2'b00 || grant_id !== 1'b0) begin n_fail++; $display("FAIL wr_access: got rsp %b gid %b want 00/0", rsp_valid, grant_id); end
        next_cycle(); #1;
        n_checks++; if (rsp_valid !== 2'b01 || rsp_err !== 1'b0 || rsp_rdata !== 8'h00) begin n_fail++; $display("FAIL wr_rsp: got %b/%b/%h want 01/0/00", rsp_valid, rsp_err, rsp_rdata); end
        n_checks++; if (bank_we !== 1'b0) begin n_fail++; $display("FAIL wr_we_resp: got %b want 0", bank_we); end
    endtask

    task automatic test_alternate();
        logic [1:0] exp;
        int         first = 1;
        for (int c = 0; c < 12; c++) begin
            next_cycle(); clear_reqs();
            set_req(0, 0, 0, 4'(c), 8'h00); set_req(1, 0, 0, 4'(c + 1), 8'h00); #1;
            exp = (c % 3 == 0) ? (2'b01 << ((first + c / 3) % 2)) : 2'b00;
            n_checks++; if (req_ready !== exp) begin n_fail++; $display("FAIL rr_ready c%0d: got %b want %b", c, req_ready, exp); end
            if (c % 3 == 2) begin
                exp = 2'b01 << ((first + c / 3) % 2);
                n_checks++; if (rsp_valid !== exp) begin n_fail++; $display("FAIL rr_rsp c%0d: got %b want %b", c, rsp_valid, exp); end
            end
        end
    endtask

    task automatic test_readonly();
        status_seed = 8'h35;  // status at address 9 reads 0x3C
        next_cycle(); clear_reqs(); set_req(0, 1, 0, 4'd9, 8'h77); #1;
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL ro_ready: got %b want 01", req_ready); end
        next_cycle(); clear_reqs(); #1;
        n_checks++; if (bank_we !== 1'b0 || bank_addr !== 4'd9) begin n_fail++; $display("FAIL ro_bank: got %b/%h want 0/9", bank_we, bank_addr); end
        next_cycle(); #1;
        n_checks++; if (rsp_valid !== 2'b01 || rsp_err !== 1'b1) begin n_fail++; $display("FAIL ro_err: got %b/%b want 01/1", rsp_valid, rsp_err); end
        next_cycle(); clear_reqs(); set_req(0, 0, 0, 4'd9, 8'h00); #1;
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL ro_rd_ready: got %b want 01", req_ready); end
        next_cycle(); clear_reqs(); next_cycle(); #1;
        n_checks++; if (rsp_valid !== 2'b01 || rsp_rdata !== 8'h3C || rsp_err !== 1'b0) begin n_fail++; $display("FAIL ro_rd: got %b/%h/%b want 01/3c/0", rsp_valid, rsp_rdata, rsp_err); end
    endtask

    task automatic test_lock();
        int blocked = 0;
        bit granted = 0;
        next_cycle(); clear_reqs(); set_req(1, 0, 1, 4'd2, 8'h00); #1;
        n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL lk_take: got %b want 10", req_ready); end
        next_cycle(); clear_reqs(); set_req(0, 0, 0, 4'd1, 8'h00);
        next_cycle();
        for (int i = 0; i < 40 && !granted; i++) begin
            next_cycle(); clear_reqs(); set_req(0, 0, 0, 4'd1, 8'h00); #1;
            if (req_ready === 2'b01) granted = 1;
            else blocked++;
        end
        n_checks++; if (!granted || blocked != 15) begin n_fail++; $display("FAIL lk_timeout: got granted=%0d blocked=%0d want 1/15", granted, blocked); end
        next_cycle(); clear_reqs(); next_cycle();
        next_cycle(); clear_reqs(); set_req(1, 1, 1, 4'd5, 8'h11); #1;
        n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL lk_take2: got %b want 10", req_ready); end
        next_cycle(); clear_reqs(); next_cycle();
        next_cycle(); clear_reqs(); set_req(1, 1, 0, 4'd6, 8'h22); set_req(0, 0, 0, 4'd0, 8'h00); #1;
        n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL lk_owner: got %b want 10", req_ready); end
        next_cycle(); clear_reqs(); next_cycle(); #1;
        n_checks++; if (rsp_valid !== 2'b10) begin n_fail++; $display("FAIL lk_rsp: got %b want 10", rsp_valid); end
        next_cycle(); clear_reqs(); set_req(0, 0, 0, 4'd0, 8'h00); set_req(1, 0, 1, 4'd0, 8'h00); #1;
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL lk_release: got %b want 01", req_ready); end
        next_cycle(); clear_reqs(); next_cycle();
    endtask

    task automatic test_ena();
        next_cycle(); clear_reqs(); set_req(0, 0, 0, 4'd2, 8'h00); #1;
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL en_ready: got %b want 01", req_ready); end
        next_cycle(); ena = 1'b0; clear_reqs(); set_req(0, 0, 0, 4'd2, 8'h00); set_req(1, 0, 0, 4'd3, 8'h00);
        next_cycle(); #1;
        n_checks++; if (rsp_valid !== 2'b01) begin n_fail++; $display("FAIL en_rsp: got %b want 01", rsp_valid); end
        for (int c = 3; c < 7; c++) begin
            next_cycle(); #1;
            n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL en_hold c%0d: got %b want 00", c, req_ready); end
        end
        next_cycle(); ena = 1'b1; #1;
        n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL en_resume: got %b want 10", req_ready); end
        next_cycle(); clear_reqs(); next_cycle();
    endtask

    task automatic test_reset_mid();
        next_cycle(); clear_reqs(); set_req(1, 1, 0, 4'd4, 8'h5A); #1;
        n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL rm_ready: got %b want 10", req_ready); end
        next_cycle(); clear_reqs(); #1;
        n_checks++; if (bank_we !== 1'b1) begin n_fail++; $display("FAIL rm_access: got %b want 1", bank_we); end
        rst = 1'b1; #1;
        n_checks++; if (bank_we !== 1'b0 || bank_addr !== 4'h0 || bank_wdata !== 8'h00) begin n_fail++; $display("FAIL rm_bank: got %b/%h/%h want 0/0/00", bank_we, bank_addr, bank_wdata); end
        n_checks++; if (rsp_rdata !== 8'h00 || rsp_err !== 1'b0 || grant_id !== 1'b0) begin n_fail++; $display("FAIL rm_rsp: got %h/%b/%b want 00/0/0", rsp_rdata, rsp_err, grant_id); end
        next_cycle(); rst = 1'b0; #1;
        n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rm_norsp: got %b want 00", rsp_valid); end
        next_cycle(); clear_reqs(); set_req(0, 0, 0, 4'd0, 8'h00); set_req(1, 0, 0, 4'd1, 8'h00); #1;
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rm_prio: got %b want 01", req_ready); end
        next_cycle(); clear_reqs(); next_cycle();
    endtask

    // Randomized traffic against a transaction-level model: each accepted request occupies
    // the port for three cycles; the winner is the first eligible requester after the last one.
    task automatic test_random();
        int         busy = 0;        // cycles left in the current transaction
        int         last = 1;        // last granted requester
        bit         locked = 0;
        int         owner = 0, idle_left = 0;
        int         cur_id = 0, w;
        bit         cur_we = 0, cur_keep = 0;
        logic [3:0] cur_addr = '0;
        logic [7:0] cur_wdata = '0, exp_rdata;
        logic [7:0] mem [8];
        logic [1:0] exp_ready, exp_rsp;
        logic       exp_gid = 1'b0;
        next_cycle(); rst = 1'b1; clear_reqs(); ena = 1'b1;
        next_cycle(); rst = 1'b0;
        status_seed = 8'($urandom);
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        for (int n = 0; n < 800; n++) begin
            next_cycle();
            ena = ($urandom_range(0, 9) != 0);
            for (int i = 0; i < 2; i++) begin
                req_valid[i] = 1'($urandom_range(0, 1));
                req_we[i]    = 1'($urandom_range(0, 1));
                req_lock[i]  = ($urandom_range(0, 4) == 0);
                req_addr[i*4 +: 4]  = 4'($urandom_range(0, 15));
                req_wdata[i*8 +: 8] = 8'($urandom);
            end
            #1;
            exp_ready = 2'b00; exp_rsp = 2'b00;
            w = -1;
            if (busy == 0) begin
                for (int k = 1; k <= 2; k++) begin
                    if (w < 0 && req_valid[(last + k) % 2] && (!locked || (last + k) % 2 == owner))
                        w = (last + k) % 2;
                end
                if (ena && w >= 0) exp_ready = 2'b01 << w;
            end else if (busy == 1) begin
                exp_rsp = 2'b01 << cur_id;
            end
            n_checks++; if (req_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready n%0d: got %b want %b", n, req_ready, exp_ready); end
            n_checks++; if (rsp_valid !== exp_rsp) begin n_fail++; $display("FAIL rnd_rsp n%0d: got %b want %b", n, rsp_valid, exp_rsp); end
            n_checks++; if (bank_we !== (busy == 2 && cur_we && cur_addr < 4'd8)) begin n_fail++; $display("FAIL rnd_we n%0d: got %b want %b", n, bank_we, (busy == 2 && cur_we && cur_addr < 4'd8)); end
            n_checks++; if (grant_id !== exp_gid) begin n_fail++; $display("FAIL rnd_gid n%0d: got %b want %b", n, grant_id, exp_gid); end
            if (busy == 2) begin
                n_checks++; if (bank_addr !== cur_addr || bank_wdata !== cur_wdata) begin n_fail++; $display("FAIL rnd_bank n%0d: got %h/%h want %h/%h", n, bank_addr, bank_wdata, cur_addr, cur_wdata); end
                exp_rdata = cur_we ? 8'h00 : ((cur_addr < 4'd8) ? mem[cur_addr[2:0]] : status_of(cur_addr));
                if (cur_we && cur_addr < 4'd8) mem[cur_addr[2:0]] = cur_wdata;
            end
            if (busy == 1) begin
                n_checks++; if (rsp_rdata !== exp_rdata || rsp_err !== (cur_we && cur_addr >= 4'd8)) begin n_fail++; $display("FAIL rnd_data n%0d: got %h/%b want %h/%b", n, rsp_rdata, rsp_err, exp_rdata, (cur_we && cur_addr >= 4'd8)); end
                if (!cur_keep) locked = 0;
            end
            // Advance the model across the clock edge.
            if (busy > 0) begin
                busy--;
            end else if (ena && w >= 0) begin
                busy = 2; last = w; cur_id = w; exp_gid = 1'(w);
                cur_we = req_we[w]; cur_keep = req_lock[w];
                cur_addr = req_addr[w*4 +: 4]; cur_wdata = req_wdata[w*8 +: 8];
                if (cur_keep) begin locked = 1; owner = w; end
                idle_left = 15;
            end else if (locked && ena && !req_valid[owner]) begin
                idle_left--;
                if (idle_left == 0) locked = 0;
            end
        end
        next_cycle(); clear_reqs(); ena = 1'b1;
    endtask

    initial begin
        clear_reqs();
        test_reset();
        test_write_basic();
        test_alternate();
        test_readonly();
        test_lock();
        test_ena();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
